div_sched: RTL and testbench

- Sequencing controller between the EX stage and a single shared unsigned AXI-Stream divider core.
- Accepts one divide/modulo request at a time: div.w, mod.w, div.wu or mod.wu.
- Performs sign pre-conditioning and runs the dividend/divisor stream handshakes.
- Sign-corrects the selected quotient or remainder and holds it until EX consumes it.
- Absorbs pipeline flushes safely while an operation is in flight inside the core.

---
 rtl/div_sched.sv | 171 +++++++++++++++++
 tb/tb_div_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sched.sv
// Sequences one div/mod request at a time through a shared unsigned divider core, with sign fix-up and flush absorption.
// Result is registered one cycle after the core's dout pulse (zero-divisor bypass answers the cycle after accept); req_ready is low until EX takes the held result.
module div_sched #(
    parameter bit ZERO_BYPASS = 1'b1,
    parameter bit QUOT_HI     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        busy,
    output logic        div_dividend_tvalid,
    input  logic        div_dividend_tready,
    output logic [31:0] div_dividend_tdata,
    output logic        div_divisor_tvalid,
    input  logic        div_divisor_tready,
    output logic [31:0] div_divisor_tdata,
    input  logic        div_dout_tvalid,
    input  logic [63:0] div_dout_tdata
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  op_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic        cancel;

    logic        accept;
    logic        zero_byp;
    logic        dvd_done;
    logic        dvs_done;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] sel;
    logic        sel_neg;
    logic [31:0] fixed;

    assign req_ready = (state == IDLE) & ~flush;
    assign accept    = req_valid & req_ready;
    assign busy      = (state != IDLE);
    assign zero_byp  = ZERO_BYPASS & (req_src2 == 32'd0);

    // A channel is finished once its tvalid has dropped or it handshakes this cycle
    assign dvd_done = ~div_dividend_tvalid | div_dividend_tready;
    assign dvs_done = ~div_divisor_tvalid  | div_divisor_tready;

    assign abs1 = req_src1[31] ? (~req_src1 + 32'd1) : req_src1;
    assign abs2 = req_src2[31] ? (~req_src2 + 32'd1) : req_src2;

    assign quot    = QUOT_HI ? div_dout_tdata[63:32] : div_dout_tdata[31:0];
    assign rem     = QUOT_HI ? div_dout_tdata[31:0]  : div_dout_tdata[63:32];
    assign sel     = op_q[0] ? rem : quot;
    assign sel_neg = ~op_q[1] & (op_q[0] ? r_neg_q : q_neg_q);
    assign fixed   = sel_neg ? (~sel + 32'd1) : sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = zero_byp ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (dvd_done && dvs_done) begin
                    state_nxt = (cancel || flush) ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (div_dout_tvalid) begin
                    state_nxt = flush ? IDLE : DONE;
                end else if (flush) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (div_dout_tvalid) begin
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                if (resp_ready || flush) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q                <= 2'd0;
            q_neg_q             <= 1'b0;
            r_neg_q             <= 1'b0;
            cancel              <= 1'b0;
            resp_valid          <= 1'b0;
            resp_result         <= 32'd0;
            div_dividend_tvalid <= 1'b0;
            div_dividend_tdata  <= 32'd0;
            div_divisor_tvalid  <= 1'b0;
            div_divisor_tdata   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q               <= req_op;
                        q_neg_q            <= req_src1[31] ^ req_src2[31];
                        r_neg_q            <= req_src1[31];
                        div_dividend_tdata <= req_op[1] ? req_src1 : abs1;
                        div_divisor_tdata  <= req_op[1] ? req_src2 : abs2;
                        if (zero_byp) begin
                            resp_valid  <= 1'b1;
                            resp_result <= req_op[0] ? req_src1 : 32'hFFFF_FFFF;
                        end else begin
                            div_dividend_tvalid <= 1'b1;
                            div_divisor_tvalid  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (div_dividend_tvalid && div_dividend_tready) begin
                        div_dividend_tvalid <= 1'b0;
                    end
                    if (div_divisor_tvalid && div_divisor_tready) begin
                        div_divisor_tvalid <= 1'b0;
                    end
                    // Operands may already be committed to the core, so remember to drain its answer
                    if (flush) begin
                        cancel <= 1'b1;
                    end
                end
                WAIT: begin
                    if (div_dout_tvalid && !flush) begin
                        resp_valid  <= 1'b1;
                        resp_result <= fixed;
                    end
                end
                DRAIN: begin
                    if (div_dout_tvalid) begin
                        cancel <= 1'b0;
                    end
                end
                DONE: begin
                    if (resp_ready || flush) begin
                        resp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched: the bench plays the divider core and EX with hand-computed vectors.
module tb_div_sched;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        busy;
    logic        div_dividend_tvalid;
    logic        div_dividend_tready;
    logic [31:0] div_dividend_tdata;
    logic        div_divisor_tvalid;
    logic        div_divisor_tready;
    logic [31:0] div_divisor_tdata;
    logic        div_dout_tvalid;
    logic [63:0] div_dout_tdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_sched #(.ZERO_BYPASS(1'b1), .QUOT_HI(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result), .busy(busy),
        .div_dividend_tvalid(div_dividend_tvalid), .div_dividend_tready(div_dividend_tready),
        .div_dividend_tdata(div_dividend_tdata),
        .div_divisor_tvalid(div_divisor_tvalid), .div_divisor_tready(div_divisor_tready),
        .div_divisor_tdata(div_divisor_tdata),
        .div_dout_tvalid(div_dout_tvalid), .div_dout_tdata(div_dout_tdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a request and walk it to DONE with the core always ready; returns observations only.
    task automatic drive_to_done(input logic [1:0] op, input logic [31:0] s1, input logic [31:0] s2,
                                 input logic [63:0] dout, output logic rdy0, output logic [31:0] dvd,
                                 output logic [31:0] dvs, output logic both_vld);
        req_valid = 1'b1; req_op = op; req_src1 = s1; req_src2 = s2;
        rdy0 = req_ready;
        tick();
        req_valid = 1'b0;
        dvd = div_dividend_tdata; dvs = div_divisor_tdata;
        both_vld = div_dividend_tvalid & div_divisor_tvalid;
        tick();
        div_dout_tvalid = 1'b1; div_dout_tdata = dout;
        tick();
        div_dout_tvalid = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] s1, input logic [31:0] s2,
                          input logic [63:0] dout, output logic rdy0, output logic [31:0] dvd,
                          output logic [31:0] dvs, output logic both_vld, output logic rv,
                          output logic [31:0] res);
        drive_to_done(op, s1, s2, dout, rdy0, dvd, dvs, both_vld);
        rv = resp_valid; res = resp_result;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_src1 = '0; req_src2 = '0;
        flush = 1'b0; resp_ready = 1'b0; div_dividend_tready = 1'b1; div_divisor_tready = 1'b1;
        div_dout_tvalid = 1'b0; div_dout_tdata = '0;
        repeat (3) tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset resp_valid: got %b want 0", resp_valid); end
        checks++; if (resp_result !== 32'd0) begin errors++; $display("FAIL reset resp_result: got %h want 0", resp_result); end
        checks++; if ({div_dividend_tvalid, div_divisor_tvalid} !== 2'b00) begin errors++; $display("FAIL reset tvalids: got %b want 00", {div_dividend_tvalid, div_divisor_tvalid}); end
        checks++; if ({div_dividend_tdata, div_divisor_tdata} !== 64'd0) begin errors++; $display("FAIL reset tdata: got %h want 0", {div_dividend_tdata, div_divisor_tdata}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        reset = 1'b0;
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_signed();
        logic rdy0, both, rv; logic [31:0] dvd, dvs, res;
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, {32'd3, 32'd1}, rdy0, dvd, dvs, both, rv, res);
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL signed req_ready: got %b want 1", rdy0); end
        checks++; if (both !== 1'b1) begin errors++; $display("FAIL signed tvalids: got %b want 1", both); end
        checks++; if (dvd !== 32'd7) begin errors++; $display("FAIL signed dividend tdata: got %h want 7", dvd); end
        checks++; if (dvs !== 32'd2) begin errors++; $display("FAIL signed divisor tdata: got %h want 2", dvs); end
        checks++; if (rv !== 1'b1) begin errors++; $display("FAIL signed resp_valid latency: got %b want 1", rv); end
        checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_w -7/2: got %h want fffffffd", res); end
        run_op(2'b01, 32'hFFFF_FFF9, 32'd2, {32'd3, 32'd1}, rdy0, dvd, dvs, both, rv, res);
        checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mod_w -7/2: got %h want ffffffff", res); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL signed consume: resp_valid got %b want 0", resp_valid); end
    endtask

    task automatic test_unsigned();
        logic rdy0, both, rv; logic [31:0] dvd, dvs, res;
        run_op(2'b10, 32'hFFFF_FFFF, 32'h10, {32'h0FFF_FFFF, 32'hF}, rdy0, dvd, dvs, both, rv, res);
        checks++; if (dvd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_wu dividend tdata: got %h want ffffffff", dvd); end
        checks++; if (dvs !== 32'h10) begin errors++; $display("FAIL div_wu divisor tdata: got %h want 10", dvs); end
        checks++; if (res !== 32'h0FFF_FFFF) begin errors++; $display("FAIL div_wu result: got %h want 0fffffff", res); end
    endtask

    task automatic test_overflow();
        logic rdy0, both, rv; logic [31:0] dvd, dvs, res;
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, rdy0, dvd, dvs, both, rv, res);
        checks++; if (dvd !== 32'h8000_0000) begin errors++; $display("FAIL ovf dividend tdata: got %h want 80000000", dvd); end
        checks++; if (dvs !== 32'd1) begin errors++; $display("FAIL ovf divisor tdata: got %h want 1", dvs); end
        checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL ovf div_w result: got %h want 80000000", res); end
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, rdy0, dvd, dvs, both, rv, res);
        checks++; if (res !== 32'd0) begin errors++; $display("FAIL ovf mod_w result: got %h want 0", res); end
    endtask

    task automatic test_zero_bypass();
        req_valid = 1'b1; req_op = 2'b11; req_src1 = 32'h1234; req_src2 = 32'd0;
        tick();
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bypass resp_valid cycle1: got %b want 1", resp_valid); end
        checks++; if (resp_result !== 32'h1234) begin errors++; $display("FAIL bypass mod_wu result: got %h want 1234", resp_result); end
        checks++; if ({div_dividend_tvalid, div_divisor_tvalid} !== 2'b00) begin errors++; $display("FAIL bypass tvalids: got %b want 00", {div_dividend_tvalid, div_divisor_tvalid}); end
        tick();
        checks++; if ({div_dividend_tvalid, div_divisor_tvalid} !== 2'b00) begin errors++; $display("FAIL bypass tvalids later: got %b want 00", {div_dividend_tvalid, div_divisor_tvalid}); end
        resp_ready = 1'b1; tick(); resp_ready = 1'b0;
        req_valid = 1'b1; req_op = 2'b00; req_src1 = 32'd5; req_src2 = 32'd0;
        tick();
        req_valid = 1'b0;
        checks++; if (resp_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bypass div_w result: got %h want ffffffff", resp_result); end
        resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        req_valid = 1'b1; req_op = 2'b10; req_src1 = 32'd50; req_src2 = 32'd5;
        tick();
        req_valid = 1'b0; div_divisor_tready = 1'b0;
        checks++; if ({div_dividend_tvalid, div_divisor_tvalid} !== 2'b11) begin errors++; $display("FAIL bp issue tvalids: got %b want 11", {div_dividend_tvalid, div_divisor_tvalid}); end
        tick();
        checks++; if ({div_dividend_tvalid, div_divisor_tvalid} !== 2'b01) begin errors++; $display("FAIL bp after dividend hs: got %b want 01", {div_dividend_tvalid, div_divisor_tvalid}); end
        checks++; if (div_divisor_tdata !== 32'd5) begin errors++; $display("FAIL bp divisor tdata: got %h want 5", div_divisor_tdata); end
        div_dout_tvalid = 1'b1; div_dout_tdata = {32'd99, 32'd99};
        tick();
        div_dout_tvalid = 1'b0;
        checks++; if (div_divisor_tvalid !== 1'b1) begin errors++; $display("FAIL bp divisor held: got %b want 1", div_divisor_tvalid); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp dout in issue ignored: resp_valid got %b want 0", resp_valid); end
        checks++; if (div_divisor_tdata !== 32'd5) begin errors++; $display("FAIL bp divisor tdata stable: got %h want 5", div_divisor_tdata); end
        div_divisor_tready = 1'b1;
        tick();
        checks++; if (div_divisor_tvalid !== 1'b0) begin errors++; $display("FAIL bp divisor drop: got %b want 0", div_divisor_tvalid); end
        div_dout_tvalid = 1'b1; div_dout_tdata = {32'd10, 32'd0};
        tick();
        div_dout_tvalid = 1'b0;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp resp_valid: got %b want 1", resp_valid); end
        checks++; if (resp_result !== 32'd10) begin errors++; $display("FAIL bp result: got %h want a", resp_result); end
        resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic rdy0, both, rv; logic [31:0] dvd, dvs, res;
        req_valid = 1'b1; req_op = 2'b00; req_src1 = 32'd20; req_src2 = 32'd3;
        tick();
        req_valid = 1'b0;
        tick();
        flush = 1'b1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush wait req_ready: got %b want 0", req_ready); end
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({req_ready, resp_valid} !== 2'b00) begin errors++; $display("FAIL flush drain cycle %0d ready/valid: got %b want 00", i, {req_ready, resp_valid}); end
            tick();
        end
        div_dout_tvalid = 1'b1; div_dout_tdata = {32'd6, 32'd2};
        tick();
        div_dout_tvalid = 1'b0;
        checks++; if ({req_ready, resp_valid} !== 2'b10) begin errors++; $display("FAIL flush after stale dout ready/valid: got %b want 10", {req_ready, resp_valid}); end
        run_op(2'b10, 32'd100, 32'd7, {32'd14, 32'd2}, rdy0, dvd, dvs, both, rv, res);
        checks++; if (res !== 32'd14) begin errors++; $display("FAIL flush next div_wu 100/7: got %h want e", res); end
        // flush and dout in the same cycle
        req_valid = 1'b1; req_op = 2'b00; req_src1 = 32'd9; req_src2 = 32'd4;
        tick();
        req_valid = 1'b0;
        tick();
        flush = 1'b1; div_dout_tvalid = 1'b1; div_dout_tdata = {32'd2, 32'd1};
        tick();
        flush = 1'b0; div_dout_tvalid = 1'b0;
        checks++; if ({busy, resp_valid} !== 2'b00) begin errors++; $display("FAIL flush+dout busy/valid: got %b want 00", {busy, resp_valid}); end
        // flush while the divisor is still stalled in ISSUE
        req_valid = 1'b1; req_op = 2'b10; req_src1 = 32'd8; req_src2 = 32'd2;
        div_divisor_tready = 1'b0;
        tick();
        req_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; div_divisor_tready = 1'b1;
        checks++; if (div_divisor_tvalid !== 1'b1) begin errors++; $display("FAIL flush issue tvalid retracted: got %b want 1", div_divisor_tvalid); end
        tick();
        checks++; if ({busy, div_divisor_tvalid} !== 2'b10) begin errors++; $display("FAIL flush issue drain busy/tvalid: got %b want 10", {busy, div_divisor_tvalid}); end
        div_dout_tvalid = 1'b1; div_dout_tdata = {32'd4, 32'd0};
        tick();
        div_dout_tvalid = 1'b0;
        checks++; if ({busy, resp_valid} !== 2'b00) begin errors++; $display("FAIL flush issue end busy/valid: got %b want 00", {busy, resp_valid}); end
    endtask

    task automatic test_hold();
        logic rdy0, both; logic [31:0] dvd, dvs;
        drive_to_done(2'b00, 32'd100, 32'hFFFF_FFF9, {32'd14, 32'd2}, rdy0, dvd, dvs, both);
        for (int i = 0; i < 5; i++) begin
            checks++; if ({resp_valid, req_ready, resp_result} !== {2'b10, 32'hFFFF_FFF2}) begin errors++; $display("FAIL hold cycle %0d valid/ready/result: got %b %b %h want 1 0 fffffff2", i, resp_valid, req_ready, resp_result); end
            tick();
        end
        resp_ready = 1'b1; tick(); resp_ready = 1'b0;
        checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL hold consume valid/ready: got %b want 01", {resp_valid, req_ready}); end
        drive_to_done(2'b10, 32'd100, 32'd7, {32'd14, 32'd2}, rdy0, dvd, dvs, both);
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if ({resp_valid, busy} !== 2'b00) begin errors++; $display("FAIL flush in done valid/busy: got %b want 00", {resp_valid, busy}); end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_op = 2'b10; req_src1 = 32'd30; req_src2 = 32'd3;
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b1;
        #2;
        checks++; if ({busy, div_dividend_tvalid, div_divisor_tvalid} !== 3'b000) begin errors++; $display("FAIL reset mid busy/tvalids: got %b want 000", {busy, div_dividend_tvalid, div_divisor_tvalid}); end
        reset = 1'b0;
        tick();
        div_dout_tvalid = 1'b1; div_dout_tdata = {32'd10, 32'd0};
        tick();
        div_dout_tvalid = 1'b0;
        checks++; if ({busy, resp_valid, req_ready} !== 3'b001) begin errors++; $display("FAIL reset mid stray dout busy/valid/ready: got %b want 001", {busy, resp_valid, req_ready}); end
    endtask

    initial begin
        test_reset();
        test_signed();
        test_unsigned();
        test_overflow();
        test_zero_bypass();
        test_backpressure();
        test_flush();
        test_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
